// File: rtl/mem_access_unit.sv
// Load/store stage: drives the byte-enabled data RAM and the LED/switch registers.
// Optional MEM_ALIGN_CHECK_EN flags misaligned accesses instead of force-aligning them.
module mem_access_unit #(
    parameter int          RAM_AW   = 14,
    parameter logic [31:0] LED_ADDR = 32'hFFFF_FC60,
    parameter logic [31:0] SW_ADDR  = 32'hFFFF_FC70
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [5:0]        mem_opcode,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       store_data,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_we,
    input  logic [31:0]       ram_rdata,
    input  logic [23:0]       io_switch,
    output logic [23:0]       io_led,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              stall,
    output logic              misaligned
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    localparam logic [1:0] SRC_RAM  = 2'd0;
    localparam logic [1:0] SRC_SW   = 2'd1;
    localparam logic [1:0] SRC_ZERO = 2'd2;

    state_t state, state_nxt;

    logic       sz_byte, sz_half, sz_word;
    logic [1:0] eff_off;
    logic       mis_req;
    logic [3:0] lane_mask;
    logic       is_io, led_hit, sw_hit;
    logic       rd_req, wr_req, wr_ok;

    logic [1:0] off_q;
    logic       byte_q, half_q, uns_q;
    logic [1:0] src_q;
    logic [31:0] raw, shifted, fmt;

    logic unused_ok;
    assign unused_ok = &{1'b0, mem_opcode[5:3]};

    // Access size comes from the low opcode bits for both loads and stores
    always_comb begin
        sz_byte = (mem_opcode[1:0] == 2'b00);
        sz_half = (mem_opcode[1:0] == 2'b01);
        sz_word = !sz_byte && !sz_half;
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_req = (sz_half && alu_result[0]) || (sz_word && (alu_result[1:0] != 2'b00));
    assign eff_off = alu_result[1:0];
`else
    assign mis_req = 1'b0;
    always_comb begin
        eff_off = alu_result[1:0];
        if (sz_word)      eff_off = 2'b00;
        else if (sz_half) eff_off = {alu_result[1], 1'b0};
    end
`endif

    always_comb begin
        lane_mask = 4'b1111;
        if (sz_byte)      lane_mask = 4'b0001 << eff_off;
        else if (sz_half) lane_mask = eff_off[1] ? 4'b1100 : 4'b0011;
    end

    always_comb begin
        ram_wdata = store_data;
        if (sz_byte)      ram_wdata = {4{store_data[7:0]}};
        else if (sz_half) ram_wdata = {2{store_data[15:0]}};
    end

    assign ram_addr = alu_result[RAM_AW+1:2];
    assign is_io    = &alu_result[31:10];
    assign led_hit  = is_io && (alu_result[31:2] == LED_ADDR[31:2]);
    assign sw_hit   = is_io && (alu_result[31:2] == SW_ADDR[31:2]);

    // A simultaneous read and write request is served as a read
    assign rd_req = (state == IDLE) && mem_read;
    assign wr_req = (state == IDLE) && mem_write && !mem_read;
    assign wr_ok  = wr_req && !mis_req && !reset;

    assign ram_we = (wr_ok && !is_io) ? lane_mask : 4'b0000;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (mem_read) state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            off_q  <= 2'b00;
            byte_q <= 1'b0;
            half_q <= 1'b0;
            uns_q  <= 1'b0;
            src_q  <= SRC_ZERO;
        end else if (rd_req) begin
            off_q  <= eff_off;
            byte_q <= sz_byte;
            half_q <= sz_half;
            uns_q  <= mem_opcode[2];
            src_q  <= !is_io ? SRC_RAM : (sw_hit ? SRC_SW : SRC_ZERO);
        end
    end

    always_comb begin
        raw = 32'h0;
        unique case (src_q)
            SRC_RAM: raw = ram_rdata;
            SRC_SW:  raw = {8'h00, io_switch};
            default: raw = 32'h0;
        endcase
        shifted = raw >> {off_q, 3'b000};
        fmt = shifted;
        if (byte_q)
            fmt = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        else if (half_q)
            fmt = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic mis_q;

    always_ff @(posedge clock) begin
        if (reset)       mis_q <= 1'b0;
        else if (rd_req) mis_q <= mis_req;
    end

    always_ff @(posedge clock) begin
        if (reset)                  load_data <= 32'h0;
        else if (state == RD_WAIT) load_data <= mis_q ? 32'h0 : fmt;
    end

    assign misaligned = !reset && ((wr_req && mis_req) || ((state == RESP) && mis_q));
`else
    always_ff @(posedge clock) begin
        if (reset)                  load_data <= 32'h0;
        else if (state == RD_WAIT) load_data <= fmt;
    end

    assign misaligned = 1'b0;
`endif

    // Only the low three lanes exist in the LED register
    always_ff @(posedge clock) begin
        if (reset) begin
            io_led <= 24'h0;
        end else if (wr_ok && led_hit) begin
            for (int i = 0; i < 3; i++)
                if (lane_mask[i]) io_led[i*8 +: 8] <= ram_wdata[i*8 +: 8];
        end
    end

    always_comb begin
        stall      = !reset && (rd_req || (state == RD_WAIT));
        load_valid = (state == RESP);
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-enabled RAM model.
// Define MEM_ALIGN_CHECK_EN to exercise the alignment-fault paths.
module tb_mem_access_unit;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [31:0] LED_A = 32'hFFFF_FC60;
    localparam logic [31:0] SW_A  = 32'hFFFF_FC70;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [5:0]  mem_opcode;
    logic [31:0] alu_result, store_data;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;
    logic [23:0] io_switch, io_led;
    logic [31:0] load_data;
    logic        load_valid, stall, misaligned;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:16383];

    always #5 clock = ~clock;

    mem_access_unit dut (
        .clock      (clock),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_opcode (mem_opcode),
        .alu_result (alu_result),
        .store_data (store_data),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata),
        .io_switch  (io_switch),
        .io_led     (io_led),
        .load_data  (load_data),
        .load_valid (load_valid),
        .stall      (stall),
        .misaligned (misaligned)
    );

    always @(posedge clock) begin
        for (int i = 0; i < 4; i++)
            if (ram_we[i]) mem[ram_addr][i*8 +: 8] <= ram_wdata[i*8 +: 8];
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered and left at a falling edge
    task automatic do_store(input string tag, input logic [5:0] op, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] exp_we, input logic exp_mis);
        mem_write = 1'b1; mem_opcode = op; alu_result = a; store_data = d;
        #1;
        check({tag, ".we"}, {28'h0, ram_we}, {28'h0, exp_we});
        check({tag, ".stall"}, {31'h0, stall}, 32'h0);
        check({tag, ".mis"}, {31'h0, misaligned}, {31'h0, exp_mis});
        @(negedge clock);
        mem_write = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [5:0] op, input logic [31:0] a,
                           input logic wr_too, input logic [31:0] exp, input logic exp_mis);
        mem_read = 1'b1; mem_write = wr_too; mem_opcode = op;
        alu_result = a; store_data = 32'hDEAD_BEEF;
        #1;
        check({tag, ".stallN"}, {31'h0, stall}, 32'h1);
        check({tag, ".weN"}, {28'h0, ram_we}, 32'h0);
        @(negedge clock);
        check({tag, ".stallN1"}, {31'h0, stall}, 32'h1);
        check({tag, ".vldN1"}, {31'h0, load_valid}, 32'h0);
        @(negedge clock);
        check({tag, ".vldN2"}, {31'h0, load_valid}, 32'h1);
        check({tag, ".stallN2"}, {31'h0, stall}, 32'h0);
        check({tag, ".data"}, load_data, exp);
        check({tag, ".mis"}, {31'h0, misaligned}, {31'h0, exp_mis});
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_opcode = 6'h0;
        alu_result = 32'h0; store_data = 32'h0; io_switch = 24'h0;
        @(negedge clock);
        @(negedge clock);
        check("rst.load_data", load_data, 32'h0);
        check("rst.load_valid", {31'h0, load_valid}, 32'h0);
        check("rst.stall", {31'h0, stall}, 32'h0);
        check("rst.ram_we", {28'h0, ram_we}, 32'h0);
        check("rst.io_led", {8'h0, io_led}, 32'h0);
        check("rst.mis", {31'h0, misaligned}, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        do_store("sw10", OP_SW, 32'h10, 32'h8000_00FF, 4'b1111, 1'b0);
        do_load("lb10", OP_LB, 32'h10, 1'b0, 32'hFFFF_FFFF, 1'b0);
        do_load("lbu10", OP_LBU, 32'h10, 1'b0, 32'h0000_00FF, 1'b0);

        do_store("sw20", OP_SW, 32'h20, 32'h1122_3344, 4'b1111, 1'b0);
        do_store("sh22", OP_SH, 32'h22, 32'h0000_ABCD, 4'b1100, 1'b0);
        do_load("lw20a", OP_LW, 32'h20, 1'b0, 32'hABCD_3344, 1'b0);
        do_store("sb21", OP_SB, 32'h21, 32'h0000_005A, 4'b0010, 1'b0);
        do_load("lw20b", OP_LW, 32'h20, 1'b0, 32'hABCD_5A44, 1'b0);
        do_load("lh22", OP_LH, 32'h22, 1'b0, 32'hFFFF_ABCD, 1'b0);
        do_load("lhu22", OP_LHU, 32'h22, 1'b0, 32'h0000_ABCD, 1'b0);
        do_load("lb23", OP_LB, 32'h23, 1'b0, 32'hFFFF_FFAB, 1'b0);

        do_store("swled", OP_SW, LED_A, 32'h00A5_5A5A, 4'b0000, 1'b0);
        check("led.word", {8'h0, io_led}, 32'h00A5_5A5A);
        do_store("sbled", OP_SB, LED_A + 32'h1, 32'h0000_0077, 4'b0000, 1'b0);
        check("led.byte", {8'h0, io_led}, 32'h00A5_775A);

        io_switch = 24'h12_3456;
        do_load("lwsw", OP_LW, SW_A, 1'b0, 32'h0012_3456, 1'b0);
        do_load("lbsw1", OP_LB, SW_A + 32'h1, 1'b0, 32'h0000_0034, 1'b0);
        do_load("lwunm", OP_LW, 32'hFFFF_FC80, 1'b0, 32'h0, 1'b0);

        do_load("rdwr", OP_LW, 32'h10, 1'b1, 32'h8000_00FF, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
        do_store("sw13", OP_SW, 32'h13, 32'hFFFF_FFFF, 4'b0000, 1'b1);
        do_load("lw10chk", OP_LW, 32'h10, 1'b0, 32'h8000_00FF, 1'b0);
        do_store("swledmis", OP_SW, LED_A + 32'h2, 32'h0011_2233, 4'b0000, 1'b1);
        check("led.mis", {8'h0, io_led}, 32'h00A5_775A);
        do_load("lh11", OP_LH, 32'h11, 1'b0, 32'h0, 1'b1);
`else
        do_load("lh11", OP_LH, 32'h11, 1'b0, 32'h0000_00FF, 1'b0);
        do_store("sw13", OP_SW, 32'h13, 32'h0102_0304, 4'b1111, 1'b0);
        do_load("lw10chk", OP_LW, 32'h10, 1'b0, 32'h0102_0304, 1'b0);
`endif

        mem_read = 1'b1; mem_opcode = OP_LW; alu_result = 32'h20;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rstmid.stall", {31'h0, stall}, 32'h0);
        @(negedge clock);
        reset = 1'b0; mem_read = 1'b0;
        #1;
        check("rstmid.vld", {31'h0, load_valid}, 32'h0);
        check("rstmid.stall2", {31'h0, stall}, 32'h0);
        check("rstmid.led", {8'h0, io_led}, 32'h0);
        @(negedge clock);
        check("rstmid.vld2", {31'h0, load_valid}, 32'h0);
        do_load("lwpost", OP_LW, 32'h20, 1'b0, 32'hABCD_5A44, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
